// File: rtl/mips_dbg_pkg.sv
// Shared debug-path types: dump FSM state encoding and register-file sizing.
package mips_dbg_pkg;

  localparam int REG_COUNT  = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_SUM   = 2'd3
  } dump_state_e;

endpackage

// File: rtl/reg_dump_reader.sv
// Streams register-file contents as (index, value) beats over valid/ready.
// Define REG_DUMP_CHECKSUM_EN to append an XOR checksum beat after the dump.
module reg_dump_reader
  import mips_dbg_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = REG_COUNT - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_sum,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_REG);
`ifdef REG_DUMP_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] out_idx_q, out_idx_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              done_q, done_d;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
  logic              out_sum_q, out_sum_d;
`endif

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    out_idx_d   = out_idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
    csum_d      = csum_q;
    out_sum_d   = out_sum_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_FETCH;
          rd_addr_d = FIRST_A;
`ifdef REG_DUMP_CHECKSUM_EN
          csum_d    = '0;
`endif
        end
      end
      ST_FETCH: begin
        out_data_d  = rd_data;
        out_idx_d   = rd_addr_q;
        out_valid_d = 1'b1;
        out_last_d  = (rd_addr_q == LAST_A) && !CSUM_EN;
`ifdef REG_DUMP_CHECKSUM_EN
        out_sum_d   = 1'b0;
`endif
        state_d     = ST_SEND;
      end
      ST_SEND: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
          csum_d      = csum_q ^ out_data_q;
`endif
          if (out_idx_q != LAST_A) begin
            rd_addr_d = rd_addr_q + 1'b1;
            state_d   = ST_FETCH;
          end else begin
`ifdef REG_DUMP_CHECKSUM_EN
            // Checksum beat folds in the last register as it is accepted
            out_data_d  = csum_q ^ out_data_q;
            out_valid_d = 1'b1;
            out_last_d  = 1'b1;
            out_sum_d   = 1'b1;
            state_d     = ST_SUM;
`else
            done_d  = 1'b1;
            state_d = ST_IDLE;
`endif
          end
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      ST_SUM: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rd_addr_q   <= '0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

`ifdef REG_DUMP_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q    <= '0;
      out_sum_q <= 1'b0;
    end else begin
      csum_q    <= csum_d;
      out_sum_q <= out_sum_d;
    end
  end
  assign out_sum = out_sum_q;
`else
  assign out_sum = 1'b0;
`endif

  assign rd_addr   = rd_addr_q;
  assign out_idx   = out_idx_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: table of dump scenarios against a beat-list model,
// plus hand sequences for abort, single-register range and mid-dump reset.
module tb_reg_dump_reader;
  localparam int DW = 32;
  localparam int AW = 5;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] regs [32];

  logic          start = 0, abort = 0, out_ready = 0;
  logic [AW-1:0] rd_addr, out_idx;
  logic [DW-1:0] rd_data, out_data;
  logic          out_valid, out_last, out_sum, busy, done;
  assign rd_data = regs[rd_addr];

  logic          start2 = 0, abort2 = 0, ready2 = 0;
  logic [AW-1:0] rd_addr2, out_idx2;
  logic [DW-1:0] rd_data2, out_data2;
  logic          out_valid2, out_last2, out_sum2, busy2, done2;
  assign rd_data2 = regs[rd_addr2];

  reg_dump_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_idx(out_idx), .out_data(out_data),
    .out_last(out_last), .out_sum(out_sum), .busy(busy), .done(done)
  );

  reg_dump_reader #(.FIRST_REG(29), .LAST_REG(29)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
    .rd_addr(rd_addr2), .rd_data(rd_data2), .out_valid(out_valid2),
    .out_ready(ready2), .out_idx(out_idx2), .out_data(out_data2),
    .out_last(out_last2), .out_sum(out_sum2), .busy(busy2), .done(done2)
  );

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
    logic          last;
    logic          sum;
  } beat_t;
  beat_t exp_q[$];

  typedef struct {
    string name;
    int    ready_mode;
    int    fill;
    int    exp_beats;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill_regs(input int kind);
    for (int i = 0; i < 32; i++) begin
      case (kind)
        0: regs[i] = DW'(i * 32'h1111);
        1: regs[i] = $urandom;
        default: regs[i] = DW'(i);
      endcase
    end
  endtask

  // Expected stream: one beat per register, then the XOR beat if enabled
  task automatic build_exp(input int first, input int last);
    logic [DW-1:0] x;
    x = '0;
    exp_q.delete();
    for (int i = first; i <= last; i++) begin
      x ^= regs[i];
      exp_q.push_back('{AW'(i), regs[i], (i == last) && (CS == 0), 1'b0});
    end
    if (CS != 0) exp_q.push_back('{AW'(last), x, 1'b1, 1'b1});
  endtask

  task automatic cmp_beat(input string tag, input logic [AW-1:0] i,
                          input logic [DW-1:0] d, input logic l,
                          input logic s);
    beat_t b;
    if (exp_q.size() == 0) begin
      chk({tag, "_extra_beat"}, 1, 0);
    end else begin
      b = exp_q.pop_front();
      chk({tag, "_idx"}, i, b.idx);
      chk({tag, "_data"}, d, b.data);
      chk({tag, "_last"}, l, b.last);
      chk({tag, "_sum"}, s, b.sum);
    end
  endtask

  task automatic run_dump(input int mode, input int exp_n);
    bit fin, held, acc_last;
    logic [39:0] hv;
    int got_n;
    fin = 0; held = 0; acc_last = 0; got_n = 0; hv = '0;
    build_exp(0, 31);
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    chk("lat_fetch_valid", out_valid, 0);
    chk("lat_busy", busy, 1);
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge clk);
      if (c == 0) chk("lat_first_valid", out_valid, 1);
      chk("done_pulse", done, acc_last);
      if (acc_last) begin
        chk("busy_after", busy, 0);
        fin = 1;
      end else begin
        if (held)
          chk("hold_stable",
              {out_idx, out_data, out_last, out_sum, out_valid}, hv);
        case (mode)
          0: out_ready = 1;
          1: out_ready = (c % 3 == 0);
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
        held = 0;
        if (out_valid && out_ready) begin
          got_n++;
          cmp_beat("beat", out_idx, out_data, out_last, out_sum);
          acc_last = (exp_q.size() == 0);
        end else if (out_valid) begin
          held = 1;
          hv = {out_idx, out_data, out_last, out_sum, out_valid};
        end
      end
    end
    if (!fin) chk("dump_timeout", 1, 0);
    chk("beat_count", got_n, exp_n);
    out_ready = 0;
  endtask

  initial begin
    int n2, dn;
    bit seen;
    vecs[0] = '{"ready_high",  0, 0, 32 + CS};
    vecs[1] = '{"bp_1in3",     1, 0, 32 + CS};
    vecs[2] = '{"rand_ready",  2, 1, 32 + CS};
    vecs[3] = '{"seq_values",  0, 2, 32 + CS};
    vecs[4] = '{"rand_bp",     2, 1, 32 + CS};
    fill_regs(0);

    #12;
    chk("rst_outputs",
        {rd_addr, out_idx, out_data, out_valid, out_last, out_sum, busy, done},
        '0);
    chk("rst2_outputs", {out_valid2, busy2, done2, out_data2}, '0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      fill_regs(vecs[v].fill);
      run_dump(vecs[v].ready_mode, vecs[v].exp_beats);
      repeat (3) @(negedge clk);
      chk("no_extra_valid", out_valid, 0);
    end

    // Abort at idx 7 while a beat is being accepted
    fill_regs(0);
    @(negedge clk); start = 1;
    @(negedge clk); start = 0; out_ready = 1;
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (out_valid && out_idx == 7) begin
        abort = 1;
        seen = 1;
      end
    end
    if (!seen) chk("abort_reach_idx7", 0, 1);
    @(negedge clk); abort = 0; out_ready = 0;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_no_done", done, 0);
    @(negedge clk);
    chk("abort_no_done_later", done, 0);
    run_dump(0, 32 + CS);

    // Single-register range with start pulses while busy
    regs[29] = 32'hDEADBEEF;
    build_exp(29, 29);
    n2 = 0; dn = 0;
    @(negedge clk); start2 = 1;
    @(negedge clk);
    chk("range_busy", busy2, 1);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      start2 = (c < 2);
      ready2 = (c >= 2);
      if (done2) dn++;
      if (out_valid2 && ready2) begin
        n2++;
        cmp_beat("range", out_idx2, out_data2, out_last2, out_sum2);
      end
    end
    start2 = 0; ready2 = 0;
    chk("range_beats", n2, 1 + CS);
    chk("range_done_count", dn, 1);

    // Asynchronous reset in the middle of a dump
    fill_regs(1);
    @(negedge clk); start = 1;
    @(negedge clk); start = 0; out_ready = 1;
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (out_valid && out_idx == 12) seen = 1;
    end
    if (!seen) chk("reset_reach_idx12", 0, 1);
    #2 rst_n = 0;
    #1;
    chk("midreset_outputs",
        {rd_addr, out_idx, out_data, out_valid, out_last, out_sum, busy, done},
        '0);
    out_ready = 0;
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    chk("midreset_no_done", done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
